// File: rtl/regfile_mp_if.sv
// regfile_mp_if: operand read, writeback, issue and scoreboard signals of regfile_mp.
// Read/write address and data buses are flattened: port j lives at [j*W +: W].
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pending;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_busy;
    logic                flush;
    logic [AW:0]         pending_cnt;

    // decode/writeback side
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_pending, iss_busy, pending_cnt
    );

    // register file side
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_pending, iss_busy, pending_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a pending-write scoreboard.
// x0 reads as zero and is never pending; unwritten registers read zero until written.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).

// One read port: zero register, stored value gated by valid, optional forwarded value.
module regfile_mp_rdport #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] st_data,
    input  logic            st_valid,
    input  logic            st_pend,
    input  logic            byp_hit,
    input  logic [XLEN-1:0] byp_data,
    output logic [XLEN-1:0] data,
    output logic            pend
);
    // forwarded write beats stored state; a forwarded value is by definition not pending
    always_comb begin
        data = '0;
        pend = 1'b0;
        if (addr != '0) begin
            if (byp_hit) begin
                data = byp_data;
            end else begin
                data = st_valid ? st_data : '0;
                pend = st_pend;
            end
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0]               regs [NREGS];
    logic [NREGS-1:0]              valid, valid_nxt;
    logic [NREGS-1:0]              pending, pend_nxt;
    logic [AW:0]                   cnt_q, cnt_nxt;
    logic [NWR-1:0]                wr_eff;
    logic [NWR-1:0][AW-1:0]        wa;
    logic [NWR-1:0][XLEN-1:0]      wd;
    logic [NRD-1:0][XLEN-1:0]      rdata;
    logic [NRD-1:0]                rpend;

    // unpack write ports; writes to x0 are dropped here so nothing downstream sees them
    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign wa[k]     = bus.wr_addr[k*AW +: AW];
        assign wd[k]     = bus.wr_data[k*XLEN +: XLEN];
        assign wr_eff[k] = bus.wr_en[k] && (wa[k] != '0);
    end

    // next-state scoreboard: writes clear, then flush clears all, else issue sets (issue wins)
    always_comb begin
        valid_nxt = valid;
        pend_nxt  = pending;
        for (int k = 0; k < NWR; k++) begin
            if (wr_eff[k]) begin
                valid_nxt[wa[k]] = 1'b1;
                pend_nxt[wa[k]]  = 1'b0;
            end
        end
        if (bus.flush)
            pend_nxt = '0;
        else if (bus.iss_en && (bus.iss_addr != '0))
            pend_nxt[bus.iss_addr] = 1'b1;
    end

    // popcount of next-state pending, registered alongside the bits it counts
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end

    // scoreboard state; reset overrides every same-cycle event
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= '0;
            pending <= '0;
            cnt_q   <= '0;
        end else begin
            valid   <= valid_nxt;
            pending <= pend_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // data array, no reset; later ports overwrite earlier ones on address collision
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NWR; k++)
                if (wr_eff[k]) regs[wa[k]] <= wd[k];
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] bd;

        assign ra = bus.rd_addr[j*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        // forward the highest-index effective write matching this read address
        always_comb begin
            hit = 1'b0;
            bd  = '0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_eff[k] && (wa[k] == ra)) begin
                    hit = 1'b1;
                    bd  = wd[k];
                end
            end
        end
`else
        assign hit = 1'b0;
        assign bd  = '0;
`endif

        regfile_mp_rdport #(.XLEN(XLEN), .AW(AW)) u_rd (
            .addr     (ra),
            .st_data  (regs[ra]),
            .st_valid (valid[ra]),
            .st_pend  (pending[ra]),
            .byp_hit  (hit),
            .byp_data (bd),
            .data     (rdata[j]),
            .pend     (rpend[j])
        );
    end

    assign bus.rd_data     = rdata;
    assign bus.rd_pending  = rpend;
    assign bus.iss_busy    = pending[bus.iss_addr];
    assign bus.pending_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (default parameters) with hand-computed values.
module tb_regfile_mp;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int j, input logic [AW-1:0] a);
        bus.rd_addr[j*AW +: AW] = a;
    endtask

    task automatic wr(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.wr_en[k] = 1'b1;
        bus.wr_addr[k*AW +: AW] = a;
        bus.wr_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic idle();
        bus.wr_en  = '0;
        bus.iss_en = 1'b0;
        bus.flush  = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] rdat(input int j);
        return bus.rd_data[j*XLEN +: XLEN];
    endfunction

    initial begin
        reset = 1'b1;
        bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0;
        step(); step();
        reset = 1'b0;

        // 1. reset state, then write x5 and read it back a cycle later
        rd(0, 5); #1;
        chk("rst_rd_data", rdat(0), 0);
        chk("rst_rd_pend", bus.rd_pending[0], 0);
        chk("rst_cnt", bus.pending_cnt, 0);
        wr(0, 5, 32'hDEADBEEF); step(); idle(); #1;
        chk("x5_read", rdat(0), 32'hDEADBEEF);

        // 2. collision: port 1 wins; distinct addresses both commit
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); step(); idle();
        rd(0, 7); #1;
        chk("collide_x7", rdat(0), 32'h22);
        wr(0, 7, 32'h33); wr(1, 8, 32'h44); step(); idle();
        rd(1, 8); #1;
        chk("dual_x7", rdat(0), 32'h33);
        chk("dual_x8", rdat(1), 32'h44);

        // 3. issue / writeback on x9
        bus.iss_en = 1'b1; bus.iss_addr = 9; step(); idle();
        rd(0, 9); #1;
        chk("iss_x9_pend", bus.rd_pending[0], 1);
        chk("iss_x9_cnt", bus.pending_cnt, 1);
        chk("iss_x9_busy", bus.iss_busy, 1);
        wr(0, 9, 32'h99); #1;
`ifdef REGFILE_BYPASS_EN
        chk("wb_x9_samecyc_pend", bus.rd_pending[0], 0);
`else
        chk("wb_x9_samecyc_pend", bus.rd_pending[0], 1);
`endif
        step(); idle(); #1;
        chk("wb_x9_pend", bus.rd_pending[0], 0);
        chk("wb_x9_cnt", bus.pending_cnt, 0);
        chk("wb_x9_data", rdat(0), 32'h99);
        wr(0, 9, 32'hAA); bus.iss_en = 1'b1; bus.iss_addr = 9; step(); idle(); #1;
        chk("isswr_x9_pend", bus.rd_pending[0], 1);
        chk("isswr_x9_cnt", bus.pending_cnt, 1);
        chk("isswr_x9_data", rdat(0), 32'hAA);
        wr(1, 9, 32'hAB); step(); idle(); #1;
        chk("x9_clear_cnt", bus.pending_cnt, 0);

        // 4. issue x1..x4, then flush with a same-cycle issue of x6
        for (int r = 1; r <= 4; r++) begin
            bus.iss_en = 1'b1; bus.iss_addr = AW'(r); step();
        end
        idle(); #1;
        chk("iss4_cnt", bus.pending_cnt, 4);
        bus.flush = 1'b1; bus.iss_en = 1'b1; bus.iss_addr = 6; step(); idle();
        rd(0, 6); rd(1, 1); #1;
        chk("flush_cnt", bus.pending_cnt, 0);
        chk("flush_x6_pend", bus.rd_pending[0], 0);
        chk("flush_x1_pend", bus.rd_pending[1], 0);
        chk("flush_x6_busy", bus.iss_busy, 0);

        // 5. x0 ignores writes and issues
        bus.iss_en = 1'b1; bus.iss_addr = 10; wr(0, 0, 32'hFFFF); step(); idle(); #1;
        chk("x10_cnt", bus.pending_cnt, 1);
        bus.iss_en = 1'b1; bus.iss_addr = 0; wr(1, 0, 32'h1234); step(); idle();
        rd(0, 0); #1;
        chk("x0_data", rdat(0), 0);
        chk("x0_pend", bus.rd_pending[0], 0);
        chk("x0_cnt", bus.pending_cnt, 1);
        wr(0, 10, 32'h10); step(); idle(); #1;
        chk("x10_clear_cnt", bus.pending_cnt, 0);

        // 6. same-cycle write and read of x3 (pending), bypass-dependent
        wr(0, 3, 32'h12); step(); idle();
        bus.iss_en = 1'b1; bus.iss_addr = 3; step(); idle();
        rd(0, 3); wr(1, 3, 32'h55); #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_x3_data", rdat(0), 32'h55);
        chk("byp_x3_pend", bus.rd_pending[0], 0);
`else
        chk("byp_x3_data", rdat(0), 32'h12);
        chk("byp_x3_pend", bus.rd_pending[0], 1);
`endif
        step(); idle(); #1;
        chk("x3_after", rdat(0), 32'h55);
        chk("x3_after_pend", bus.rd_pending[0], 0);

        // reset mid-stream, overriding a same-cycle write and issue
        bus.iss_en = 1'b1; bus.iss_addr = 12; wr(0, 11, 32'h77);
        reset = 1'b1; step(); reset = 1'b0; idle();
        rd(0, 5); rd(1, 11); #1;
        chk("rst2_x5", rdat(0), 0);
        chk("rst2_x11", rdat(1), 0);
        chk("rst2_cnt", bus.pending_cnt, 0);
        rd(0, 7); rd(1, 12); #1;
        chk("rst2_x7", rdat(0), 0);
        chk("rst2_x12_pend", bus.rd_pending[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
